// File: rtl/key_pio_debounced.sv
// Avalon-MM input PIO with per-channel synchroniser, debounce counter,
// selectable edge capture (write-one-to-clear) and a maskable level interrupt.
module key_pio_debounced #(
  parameter int              WIDTH           = 4,
  parameter int              DEBOUNCE_CYCLES = 50000,
  parameter int              EDGE_MODE       = 0,
  parameter logic [WIDTH-1:0] INIT_VAL       = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]     MODE     = 2'(EDGE_MODE);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_update;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clear;
  logic [31:0]      w_rd_mux;
  logic             w_wr;
  logic             w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_unused = ^writedata;

  // Two-flop synchroniser on the raw inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= INIT_VAL;
      r_s2 <= INIT_VAL;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
    end
  end

  // A channel accepts its new level once it has differed for the full window.
  always_comb begin
    w_update = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_update[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  // Per-channel debounce counters; any return to the stable level restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= INIT_VAL;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_update[i]) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Edge qualification on the value being loaded into the stable register.
  always_comb begin
    case (MODE)
      2'd0:    w_event = w_update & r_s2;
      2'd1:    w_event = w_update & ~r_s2;
      default: w_event = w_update;
    endcase
  end

  // Write-one-to-clear mask for the capture register.
  always_comb begin
    if (w_wr && (address == 2'd3)) begin
      w_clear = writedata[WIDTH-1:0];
    end else begin
      w_clear = '0;
    end
  end

  // Read mux, registered below for one cycle of latency.
  always_comb begin
    case (address)
      2'd0:    w_rd_mux = 32'(r_stable);
      2'd1:    w_rd_mux = 32'(r_s2);
      2'd2:    w_rd_mux = 32'(r_irq_mask);
      2'd3:    w_rd_mux = 32'(r_edge_cap);
      default: w_rd_mux = 32'd0;
    endcase
  end

  // Bus-visible registers; a new event overrides a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= '0;
      r_edge_cap <= '0;
      r_readdata <= 32'd0;
    end else begin
      if (w_wr && (address == 2'd2)) begin
        r_irq_mask <= writedata[WIDTH-1:0];
      end else begin
        r_irq_mask <= r_irq_mask;
      end
      r_edge_cap <= (r_edge_cap & ~w_clear) | w_event;
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge_cap & r_irq_mask);

endmodule
